// File: rtl/tflaf_phase_sequencer_pkg.sv
// Shared widths, FSM state encoding and decoded phase payload for the
// log-domain sin/cos harmonic phase sequencer.
package tflaf_phase_sequencer_pkg;

  localparam int unsigned PHASE_W = 16;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned IDX_MAX = 64;
  localparam int unsigned K_W     = 4;
  // Phase bits that reach the decoder: quadrant, index and rounding bit
  localparam int unsigned DEC_W   = 9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             swap;
    logic             sin_neg;
    logic             cos_neg;
    logic             sin_zero;
    logic             cos_zero;
  } phase_fields_t;

endpackage

// File: rtl/tflaf_phase_decode.sv
// Quadrant fold of the phase accumulator into a quarter-wave LUT index,
// sin/cos swap, sign flags and exact-zero flags.
module tflaf_phase_decode
  import tflaf_phase_sequencer_pkg::*;
(
  input  logic [DEC_W-1:0] phase_hi,
  output phase_fields_t    fields
);

  logic [1:0]       quad;
  logic [IDX_W-1:0] idx;

  assign quad = phase_hi[8:7];

  // Round half up on bit 7; the 0..64 range absorbs the carry so the quadrant stays put
  assign idx = IDX_W'(phase_hi[6:1]) + IDX_W'(phase_hi[0]);

  always_comb begin
    fields          = '0;
    fields.idx      = idx;
    fields.swap     = quad[0];
    fields.sin_neg  = quad[1];
    fields.cos_neg  = quad[1] ^ quad[0];
    // LUT entry 0 means log(0): flag whichever function lands on the true zero
    fields.sin_zero = quad[0] ? (idx == IDX_W'(IDX_MAX)) : (idx == '0);
    fields.cos_zero = quad[0] ? (idx == '0) : (idx == IDX_W'(IDX_MAX));
  end

endmodule

// File: rtl/tflaf_phase_sequencer.sv
// Accepts one Q1.15 sample and emits the phases k*pi*x for k=1..P_ORDER
// as decoded LUT index/sign/zero fields over a valid/ready handshake.
module tflaf_phase_sequencer
  import tflaf_phase_sequencer_pkg::*;
#(
  parameter int unsigned P_ORDER = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] x_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [IDX_W-1:0]   idx_out,
  output logic               swap_out,
  output logic               sin_neg,
  output logic               cos_neg,
  output logic               sin_zero,
  output logic               cos_zero,
  output logic [K_W-1:0]     k_out,
  output logic               last_out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [K_W-1:0] K_LAST = K_W'(P_ORDER);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] xr_q, xr_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               ov_q, ov_d;

  phase_fields_t      dec_fields;
  phase_fields_t      out_fields;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      xr_q    <= '0;
      k_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      k_q     <= k_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state: capture in IDLE, step one harmonic per accepted output in RUN
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    xr_d    = xr_q;
    k_d     = k_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          acc_d   = x_in;
          xr_d    = x_in;
          k_d     = K_W'(1);
          ov_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (ov_q && out_ready) begin
          if (k_q == K_LAST) begin
            state_d = ST_IDLE;
            ov_d    = 1'b0;
          end else begin
            acc_d = acc_q + xr_q;
            k_d   = k_q + K_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  tflaf_phase_decode u_decode (
    .phase_hi (acc_q[PHASE_W-1 -: DEC_W]),
    .fields   (dec_fields)
  );

  // Fields read as zero whenever nothing is being offered
  assign out_fields = ov_q ? dec_fields : '0;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = ov_q;
  assign idx_out   = out_fields.idx;
  assign swap_out  = out_fields.swap;
  assign sin_neg   = out_fields.sin_neg;
  assign cos_neg   = out_fields.cos_neg;
  assign sin_zero  = out_fields.sin_zero;
  assign cos_zero  = out_fields.cos_zero;
  assign k_out     = ov_q ? k_q : '0;
  assign last_out  = ov_q && (k_q == K_LAST);

endmodule

// File: doc/tflaf_phase_sequencer.md
TFLAF_PHASE_SEQUENCER -- requirements
Module: tflaf_phase_sequencer

Interface
REQ-001 SHALL have parameter P_ORDER, default 3, meaning number of harmonics k=1..P_ORDER generated per sample (legal 1..8).
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 x_in  input  16  signed sample, Q1.15, value x in [-1,1), angle unit pi.
REQ-005 in_valid  input  1  x_in valid; in_ready  output  1  block accepts x_in.
REQ-006 idx_out  output  7  quarter-phase LUT index 0..64, drives the log sin/cos LUT x_in1.
REQ-007 swap_out  output  1  downstream uses LUT cos as sin and LUT sin as cos.
REQ-008 sin_neg, cos_neg  output  1 each  sign of sin(k*pi*x), cos(k*pi*x).
REQ-009 sin_zero, cos_zero  output  1 each  true value is 0 (LUT entry 0 means log 0, not log 1).
REQ-010 k_out  output  4  current harmonic number; last_out  output  1  k_out == P_ORDER.
REQ-011 out_valid  output  1; out_ready  input  1; valid/ready handshake on all output fields.

Function
REQ-012 FSM states: IDLE, RUN. in_ready SHALL be 1 exactly in IDLE.
REQ-013 IDLE with in_valid=1: next edge acc<=x_in, xr<=x_in, k<=1, state<=RUN; out_valid=1 the following cycle (latency 1).
REQ-014 Phase acc SHALL be 16-bit unsigned; full scale 2^16 = 2*pi; acc holds k*x mod 2^16; wrap-around is natural and required.
REQ-015 RUN with out_valid & out_ready and k<P_ORDER: acc<=acc+xr (mod 2^16), k<=k+1, out_valid stays 1.
REQ-016 RUN with out_valid & out_ready and k==P_ORDER: out_valid<=0, state<=IDLE; throughput P_ORDER+1 cycles per sample.
REQ-017 out_valid & !out_ready: all output fields SHALL hold stable.
REQ-018 Decode: q=acc[15:14]; idx = acc[13:8] + acc[7] (round-half-up), range 0..64, no carry into q.
REQ-019 q=0: swap=0, sin_neg=0, cos_neg=0. q=1: swap=1, cos_neg=1. q=2: swap=0, sin_neg=1, cos_neg=1. q=3: swap=1, sin_neg=1.
REQ-020 sin_zero = (!swap & idx==0) | (swap & idx==64); cos_zero = (!swap & idx==64) | (swap & idx==0).
REQ-021 Output fields SHALL be driven from acc/k/state registers through decode logic only; no input-to-output combinational path.
REQ-022 in_valid in RUN SHALL be ignored (not accepted, not stored).

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, acc=0, xr=0, k=0, out_valid=0; all outputs then decode to 0 except in_ready=1.
REQ-024 Reset mid-sequence SHALL abort remaining harmonics; first sample after release starts at k=1.

Structure
REQ-025 Shared package SHALL hold PHASE_W=16, IDX_W=7, IDX_MAX=64, K_W=4 and the FSM state enum.
REQ-026 Quadrant/index/zero-flag decode SHALL be one combinational sub-module, tflaf_phase_decode.

Verification
REQ-027 x_in=0x2000, P_ORDER=3, out_ready=1 -> k1: idx 32 swap0 signs 0; k2: idx 0 swap1 cos_neg1 cos_zero1; k3: idx 32 swap1 cos_neg1, last_out=1.
REQ-028 x_in=0x8000 -> k1: idx 0 swap0 sin_neg1 cos_neg1 sin_zero1; k2: acc wraps to 0x0000, idx 0 signs 0 sin_zero1.
REQ-029 x_in=0x3FC0 -> k1: idx 64, swap0, cos_zero1 (rounding boundary).
REQ-030 out_ready held 0 for 5 cycles at k=2 -> outputs frozen, k advances only after ready; in_ready=0 throughout.
REQ-031 rst_n pulsed low at k=2 asynchronously -> out_valid=0 immediately, in_ready=1; next sample emits k=1.
REQ-032 Back-to-back samples with in_valid held 1 -> exactly one idle cycle (in_ready=1) between last_out handshake and next k=1.
